serial_descrambler: RTL and testbench

Self-synchronizing serial descrambler for the G(x) = x^58 + x^39 + 1 line code. It sits on the receive side of the serial link and recovers the original bit stream from the scrambled one. It qualifies the recovered bits with a lock state machine: output is valid only after the 58-bit shift register has been flushed with line data. It also runs an idle-pattern error monitor with a saturating error counter and automatic loss-of-lock/resync.

---
 rtl/serial_descrambler.sv | 101 ++++++++++
 tb/tb_serial_descrambler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_descrambler.sv
// Self-synchronizing x^58 + x^39 + 1 descrambler with flush/lock qualification
// and an idle-zero error monitor that drops lock after a run of errors.
module serial_descrambler #(
   parameter int unsigned LOCK_BITS = 58,
   parameter int unsigned ERR_LIMIT = 8,
   parameter int unsigned ERR_CNT_W = 16
) (
   input  logic                 CLK,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 Bit_In,
   input  logic                 resync,
   input  logic                 check_en,
   input  logic                 err_clr,
   output logic                 Bit_Out,
   output logic                 Bit_Valid,
   output logic                 locked,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int unsigned LockCntW = $clog2(LOCK_BITS + 1);
   localparam int unsigned RunCntW  = $clog2(ERR_LIMIT + 1);

   typedef enum logic [0:0] {StFlush, StLocked} state_e;

   state_e               r_state;
   logic [57:0]          r_s;
   logic [LockCntW-1:0]  r_lock_cnt;
   logic [RunCntW-1:0]   r_run_cnt;
   logic                 r_bit_out;
   logic                 r_bit_valid;
   logic [ERR_CNT_W-1:0] r_err_count;

   logic w_d;
   logic w_accept;
   logic w_err;

   assign w_d      = Bit_In ^ r_s[57] ^ r_s[38];
   assign w_accept = enable && !resync;
   assign w_err    = w_accept && (r_state == StLocked) && check_en && w_d;

   always_ff @(posedge CLK) begin
      if (!reset_n) begin
         r_state     <= StFlush;
         r_s         <= '0;
         r_lock_cnt  <= '0;
         r_run_cnt   <= '0;
         r_bit_out   <= 1'b0;
         r_bit_valid <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_bit_valid <= 1'b0;

         // err_clr wins over a same-edge increment
         if (err_clr) begin
            r_err_count <= '0;
         end else if (w_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
         end

         if (resync) begin
            r_state    <= StFlush;
            r_lock_cnt <= '0;
            r_run_cnt  <= '0;
         end else if (enable) begin
            // the line bit, not the descrambled bit, feeds the shift register
            r_s       <= {r_s[56:0], Bit_In};
            r_bit_out <= w_d;
            unique case (r_state)
               StFlush: begin
                  r_lock_cnt <= r_lock_cnt + 1'b1;
                  if (r_lock_cnt == LockCntW'(LOCK_BITS - 1)) begin
                     r_state <= StLocked;
                  end
               end
               StLocked: begin
                  r_bit_valid <= 1'b1;
                  if (w_err) begin
                     if (r_run_cnt == RunCntW'(ERR_LIMIT - 1)) begin
                        r_state    <= StFlush;
                        r_lock_cnt <= '0;
                        r_run_cnt  <= '0;
                     end else begin
                        r_run_cnt <= r_run_cnt + 1'b1;
                     end
                  end else begin
                     r_run_cnt <= '0;
                  end
               end
               default: r_state <= StFlush;
            endcase
         end
      end
   end

   assign Bit_Out   = r_bit_out;
   assign Bit_Valid = r_bit_valid;
   assign locked    = (r_state == StLocked);
   assign err_count = r_err_count;

endmodule

// File: tb/tb_serial_descrambler.sv
// Randomized bench for serial_descrambler: a bit-history reference model plus a
// loopback scrambler check the recovered stream, lock timing and error monitor.
module tb_serial_descrambler;

   localparam int LOCK_BITS = 58;
   localparam int ERR_LIMIT = 8;
   localparam int ERR_CNT_W = 16;

   logic                 CLK = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 enable = 1'b0;
   logic                 Bit_In = 1'b0;
   logic                 resync = 1'b0;
   logic                 check_en = 1'b0;
   logic                 err_clr = 1'b0;
   logic                 Bit_Out;
   logic                 Bit_Valid;
   logic                 locked;
   logic [ERR_CNT_W-1:0] err_count;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   serial_descrambler #(
      .LOCK_BITS (LOCK_BITS),
      .ERR_LIMIT (ERR_LIMIT),
      .ERR_CNT_W (ERR_CNT_W)
   ) u_dut (
      .CLK       (CLK),
      .reset_n   (reset_n),
      .enable    (enable),
      .Bit_In    (Bit_In),
      .resync    (resync),
      .check_en  (check_en),
      .err_clr   (err_clr),
      .Bit_Out   (Bit_Out),
      .Bit_Valid (Bit_Valid),
      .locked    (locked),
      .err_count (err_count)
   );

   // Reference model: full history of accepted line bits since reset.
   bit m_hist[$];
   int m_since, m_run, m_err;
   bit m_locked, e_out, e_valid;

   function automatic bit m_tap(int i);
      if (i < 0) return 1'b0;
      return m_hist[i];
   endfunction

   function automatic void model_step(bit rst_n, bit en, bit b, bit rs, bit ce, bit clr);
      bit inc;
      bit d;
      inc = 1'b0;
      e_valid = 1'b0;
      if (!rst_n) begin
         m_hist.delete();
         m_since = 0; m_run = 0; m_err = 0; m_locked = 1'b0; e_out = 1'b0;
         return;
      end
      if (rs) begin
         m_since = 0; m_run = 0; m_locked = 1'b0;
      end else if (en) begin
         m_hist.push_back(b);
         d = b ^ m_tap(m_hist.size() - 59) ^ m_tap(m_hist.size() - 40);
         e_out = d;
         if (!m_locked) begin
            m_since++;
            if (m_since == LOCK_BITS) m_locked = 1'b1;
         end else begin
            e_valid = 1'b1;
            if (ce && d) begin
               inc = 1'b1;
               m_run++;
               if (m_run == ERR_LIMIT) begin
                  m_locked = 1'b0; m_since = 0; m_run = 0;
               end
            end else begin
               m_run = 0;
            end
         end
      end
      if (clr) m_err = 0;
      else if (inc && m_err < 65535) m_err++;
   endfunction

   // Loopback scrambler: c[n] = u[n] ^ c[n-39] ^ c[n-58], prehistory = seed.
   bit s_hist[$];
   bit s_seed;

   function automatic bit scramble(bit u);
      bit c;
      int n;
      n = s_hist.size();
      c = u ^ ((n >= 39) ? s_hist[n-39] : s_seed) ^ ((n >= 58) ? s_hist[n-58] : s_seed);
      s_hist.push_back(c);
      return c;
   endfunction

   task automatic step(input bit rst_n, input bit en, input bit b, input bit rs, input bit ce,
                       input bit clr);
      @(negedge CLK);
      reset_n = rst_n; enable = en; Bit_In = b; resync = rs; check_en = ce; err_clr = clr;
      model_step(rst_n, en, b, rs, ce, clr);
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({Bit_Out, Bit_Valid, locked, err_count} !== 19'd0) begin
         failures++;
         $display("FAIL reset_state got out=%b v=%b lk=%b err=%0d exp all zero",
                  Bit_Out, Bit_Valid, locked, err_count);
      end
   endtask

   task automatic test_loopback(input bit seed, input bit pattern);
      bit   u, c;
      logic [7:0] pat;
      pat = 8'h5A;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      s_hist.delete();
      s_seed = seed;
      for (int i = 1; i <= 200; i++) begin
         u = pattern ? pat[7 - ((i - 1) % 8)] : 1'($urandom);
         c = scramble(u);
         step(1'b1, 1'b1, c, 1'b0, 1'b0, 1'b0);
         checks++;
         if ({Bit_Out, Bit_Valid, locked, err_count} !==
             {e_out, e_valid, m_locked, 16'(m_err)}) begin
            failures++;
            $display("FAIL loopback_model bit=%0d got out=%b v=%b lk=%b exp out=%b v=%b lk=%b",
                     i, Bit_Out, Bit_Valid, locked, e_out, e_valid, m_locked);
         end
         checks++;
         if (i <= 58) begin
            if (Bit_Valid !== 1'b0 || locked !== (i == 58)) begin
               failures++;
               $display("FAIL loopback_flush bit=%0d got v=%b lk=%b exp v=0 lk=%b",
                        i, Bit_Valid, locked, (i == 58));
            end
         end else if (Bit_Valid !== 1'b1 || Bit_Out !== u) begin
            failures++;
            $display("FAIL loopback_source bit=%0d got out=%b v=%b exp out=%b v=1",
                     i, Bit_Out, Bit_Valid, u);
         end
      end
   endtask

   task automatic test_idle_flip();
      int epos[$];
      int got;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 200; i++) begin
         step(1'b1, 1'b1, (i == 100), 1'b0, 1'b1, 1'b0);
         if (Bit_Valid && Bit_Out) epos.push_back(i);
         checks++;
         if ({Bit_Out, Bit_Valid, locked, err_count} !==
             {e_out, e_valid, m_locked, 16'(m_err)}) begin
            failures++;
            $display("FAIL flip_model bit=%0d got out=%b v=%b lk=%b err=%0d exp %b %b %b %0d",
                     i, Bit_Out, Bit_Valid, locked, err_count, e_out, e_valid, m_locked, m_err);
         end
      end
      got = (epos.size() == 3) ? epos[0] * 1000000 + epos[1] * 1000 + epos[2] : -epos.size();
      checks++;
      if (got != 100139158) begin
         failures++;
         $display("FAIL flip_positions got code=%0d exp 100139158", got);
      end
      checks++;
      if (err_count !== 16'd3 || locked !== 1'b1) begin
         failures++;
         $display("FAIL flip_count got err=%0d lk=%b exp err=3 lk=1", err_count, locked);
      end
   endtask

   task automatic test_err_limit();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 80; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= ERR_LIMIT; k++) begin
         step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
         checks++;
         if (locked !== (k < ERR_LIMIT) || Bit_Valid !== 1'b1 || Bit_Out !== 1'b1 ||
             err_count !== 16'(k)) begin
            failures++;
            $display("FAIL err_run k=%0d got lk=%b v=%b out=%b err=%0d exp lk=%b v=1 out=1 err=%0d",
                     k, locked, Bit_Valid, Bit_Out, err_count, (k < ERR_LIMIT), k);
         end
      end
      for (int j = 1; j <= 60; j++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         checks++;
         if (locked !== (j >= 58) || Bit_Valid !== (j > 58) || err_count !== 16'd8) begin
            failures++;
            $display("FAIL relock j=%0d got lk=%b v=%b err=%0d exp lk=%b v=%b err=8",
                     j, locked, Bit_Valid, err_count, (j >= 58), (j > 58));
         end
      end
   endtask

   task automatic test_toggle_clr();
      int nvalid;
      bit en;
      nvalid = 0;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 60; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 160; i++) begin
         en = (i % 2 == 0);
         step(1'b1, en, (i == 20) ? 1'b1 : 1'($urandom & (en ? 0 : 1)), 1'b0, 1'b1, (i == 20));
         if (Bit_Valid) nvalid++;
         checks++;
         if ({Bit_Out, Bit_Valid, locked, err_count} !==
             {e_out, e_valid, m_locked, 16'(m_err)}) begin
            failures++;
            $display("FAIL toggle_model i=%0d got out=%b v=%b lk=%b err=%0d exp %b %b %b %0d",
                     i, Bit_Out, Bit_Valid, locked, err_count, e_out, e_valid, m_locked, m_err);
         end
         if (i == 20) begin
            checks++;
            if (err_count !== 16'd0 || Bit_Out !== 1'b1) begin
               failures++;
               $display("FAIL clr_collision got err=%0d out=%b exp err=0 out=1", err_count, Bit_Out);
            end
         end
      end
      checks++;
      if (nvalid != 80 || err_count !== 16'd2) begin
         failures++;
         $display("FAIL toggle_rate got valid=%0d err=%0d exp valid=80 err=2", nvalid, err_count);
      end
   endtask

   task automatic test_reset_resync();
      bit held;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < 80; i++) step(1'b1, 1'b1, 1'(i == 70), 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({Bit_Out, Bit_Valid, locked, err_count} !== 19'd0) begin
         failures++;
         $display("FAIL midrun_reset got out=%b v=%b lk=%b err=%0d exp all zero",
                  Bit_Out, Bit_Valid, locked, err_count);
      end
      for (int i = 0; i < 70; i++) begin
         step(1'b1, 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
         checks++;
         if ({Bit_Out, Bit_Valid, locked} !== {e_out, e_valid, m_locked}) begin
            failures++;
            $display("FAIL post_reset i=%0d got out=%b v=%b lk=%b exp %b %b %b",
                     i, Bit_Out, Bit_Valid, locked, e_out, e_valid, m_locked);
         end
      end
      held = Bit_Out;
      step(1'b1, 1'b1, ~held, 1'b1, 1'b0, 1'b0);
      checks++;
      if (Bit_Valid !== 1'b0 || locked !== 1'b0 || Bit_Out !== held) begin
         failures++;
         $display("FAIL resync got v=%b lk=%b out=%b exp v=0 lk=0 out=%b",
                  Bit_Valid, locked, Bit_Out, held);
      end
      for (int i = 0; i < 70; i++) begin
         step(1'b1, 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
         checks++;
         if ({Bit_Out, Bit_Valid, locked} !== {e_out, e_valid, m_locked}) begin
            failures++;
            $display("FAIL post_resync i=%0d got out=%b v=%b lk=%b exp %b %b %b",
                     i, Bit_Out, Bit_Valid, locked, e_out, e_valid, m_locked);
         end
      end
   endtask

   task automatic test_random();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
              ($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
              ($urandom_range(0, 29) == 0));
         checks++;
         if ({Bit_Out, Bit_Valid, locked, err_count} !==
             {e_out, e_valid, m_locked, 16'(m_err)}) begin
            failures++;
            $display("FAIL random_model i=%0d got out=%b v=%b lk=%b err=%0d exp %b %b %b %0d",
                     i, Bit_Out, Bit_Valid, locked, err_count, e_out, e_valid, m_locked, m_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_loopback(1'b0, 1'b0);
      test_loopback(1'b1, 1'b1);
      test_idle_flip();
      test_err_limit();
      test_toggle_clr();
      test_reset_resync();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
